// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants and state encodings for the fc input feeder
package fc_pkg;

  // Q16.16 fixed-point word width
  localparam int DATA_W   = 32;
  // Default fc input vector length and its index width
  localparam int FC_DEPTH = 1024;
  localparam int FC_IDX_W = 10;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fc_feeder_bank.sv
// rtl/fc_feeder_bank.sv - one DEPTH x DATA_W bank, synchronous write, asynchronous read
module fc_feeder_bank
  import fc_pkg::*;
#(
  parameter int DEPTH = FC_DEPTH,
  parameter int IDX_W = FC_IDX_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store a word; addresses beyond the frame length are ignored
  always_ff @(posedge clk) begin
    if (i_we && ({1'b0, i_waddr} < (IDX_W+1)'(DEPTH))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fc_feeder.sv
// rtl/fc_feeder.sv - ping-pong frame buffer streaming indexed words into the fc layer
module fc_feeder
  import fc_pkg::*;
#(
  parameter int DEPTH = FC_DEPTH,
  parameter int IDX_W = FC_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_rdy,
  input  logic              loop_en,
  input  logic              in_rdy,
  output logic              fc_valid,
  output logic [DATA_W-1:0] fc_input,
  output logic [IDX_W-1:0]  fc_in_idx,
  output logic              frame_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  bank_state_e       r_bank [2];
  logic              r_wb;
  logic              r_rb;
  logic              r_wr_rdy;
  rd_state_e         r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_done;

  logic              w_wr_fire;
  logic              w_commit;
  logic              w_start;
  logic              w_last_acc;
  logic              w_other_full;
  logic              w_release;
  logic              w_wb_nxt;
  logic              w_rd_bank;
  logic [IDX_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_rdata0;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rd_word;
  bank_state_e       w_bank_nxt [2];

  assign w_wr_fire    = wr_en & r_wr_rdy;
  assign w_commit     = wr_commit & r_wr_rdy;
  assign w_start      = (r_state == RD_IDLE) && (r_bank[r_rb] == BANK_FULL);
  assign w_last_acc   = (r_state == RD_STREAM) && in_rdy && (r_idx == LAST_IDX);
  assign w_other_full = (r_bank[~r_rb] == BANK_FULL);
  // Looping keeps the bank; otherwise the finished bank goes back to the writer
  assign w_release    = w_last_acc && (w_other_full || !loop_en);
  assign w_wb_nxt     = w_commit ? ~r_wb : r_wb;

  // Look-ahead read address: the word that will be presented after this edge
  always_comb begin
    w_rd_bank = r_rb;
    w_rd_addr = '0;
    if ((r_state == RD_STREAM) && (r_idx != LAST_IDX)) begin
      w_rd_addr = r_idx + ONE_IDX;
    end
    if (w_last_acc && w_other_full) begin
      w_rd_bank = ~r_rb;
    end
  end

  assign w_rd_word = w_rd_bank ? w_rdata1 : w_rdata0;

  // Next bank ownership: commit of the write bank and release of the read bank both apply
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_nxt[b] = r_bank[b];
      if (w_commit && (r_wb == 1'(b))) begin
        w_bank_nxt[b] = BANK_FULL;
      end
      if (w_release && (r_rb == 1'(b))) begin
        w_bank_nxt[b] = BANK_FREE;
      end
    end
  end

  fc_feeder_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank0 (
    .clk     (clk),
    .i_we    (w_wr_fire && (r_wb == 1'b0)),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata0)
  );

  fc_feeder_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank1 (
    .clk     (clk),
    .i_we    (w_wr_fire && (r_wb == 1'b1)),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata1)
  );

  // Bank states, write pointer and write-ready computed from the next bank state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank[0] <= BANK_FREE;
      r_bank[1] <= BANK_FREE;
      r_wb      <= 1'b0;
      r_wr_rdy  <= 1'b1;
    end else begin
      r_bank[0] <= w_bank_nxt[0];
      r_bank[1] <= w_bank_nxt[1];
      r_wb      <= w_wb_nxt;
      r_wr_rdy  <= (w_bank_nxt[w_wb_nxt] == BANK_FREE);
    end
  end

  // Read FSM with registered index, data, valid and frame_done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RD_IDLE;
      r_rb    <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        RD_IDLE: begin
          if (w_start) begin
            r_state <= RD_STREAM;
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_data  <= w_rd_word;
          end
        end
        RD_STREAM: begin
          if (in_rdy) begin
            if (r_idx != LAST_IDX) begin
              r_idx  <= r_idx + ONE_IDX;
              r_data <= w_rd_word;
            end else begin
              r_done <= 1'b1;
              r_idx  <= '0;
              if (w_other_full) begin
                r_rb   <= ~r_rb;
                r_data <= w_rd_word;
              end else if (loop_en) begin
                r_data <= w_rd_word;
              end else begin
                r_rb    <= ~r_rb;
                r_state <= RD_IDLE;
                r_valid <= 1'b0;
                r_data  <= '0;
              end
            end
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  assign wr_rdy     = r_wr_rdy;
  assign fc_valid   = r_valid;
  assign fc_input   = r_data;
  assign fc_in_idx  = r_idx;
  assign frame_done = r_done;

endmodule

// File: tb/tb_fc_feeder.sv
// tb/tb_fc_feeder.sv - directed self-checking bench for fc_feeder
module tb_fc_feeder;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic        wr_rdy;
  logic        loop_en;
  logic        in_rdy;
  logic        fc_valid;
  logic [31:0] fc_input;
  logic [9:0]  fc_in_idx;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  fc_feeder #(.DEPTH(1024), .IDX_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_rdy     (wr_rdy),
    .loop_en    (loop_en),
    .in_rdy     (in_rdy),
    .fc_valid   (fc_valid),
    .fc_input   (fc_input),
    .fc_in_idx  (fc_in_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input int v);
    logic [31:0] t;
    t = 32'(v);
    return {t[15:0], 16'h0000};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; in_rdy = 1'b0; loop_en = 1'b0;
    wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_frame(input int base, input int step);
    for (int i = 0; i < 1024; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = word_of(base + step * i);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic commit_frame();
    wr_commit = 1'b1;
    @(negedge clk);
    wr_commit = 1'b0;
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 8 && !fc_valid; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_rdy: got %b want 1", wr_rdy); end
    n_checks++; if (fc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fc_valid: got %b want 0", fc_valid); end
    n_checks++; if (fc_input !== 32'h0) begin n_fail++; $display("FAIL reset_fc_input: got %h want 0", fc_input); end
    n_checks++; if (fc_in_idx !== 10'd0) begin n_fail++; $display("FAIL reset_fc_in_idx: got %0d want 0", fc_in_idx); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_single_frame();
    int errs = 0;
    int fd = 0;
    do_reset();
    fill_frame(0, 1);
    commit_frame();
    n_checks++; if (fc_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: fc_valid got %b want 0 one cycle after commit", fc_valid); end
    @(negedge clk);
    n_checks++; if (fc_valid !== 1'b1 || fc_in_idx !== 10'd0 || fc_input !== 32'h0) begin
      n_fail++; $display("FAIL latency_2cyc: valid=%b idx=%0d data=%h want 1/0/00000000", fc_valid, fc_in_idx, fc_input);
    end
    in_rdy = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      if (fc_valid !== 1'b1 || fc_in_idx !== 10'(k) || fc_input !== word_of(k)) begin
        if (errs == 0) $display("note single_stream first bad k=%0d idx=%0d data=%h", k, fc_in_idx, fc_input);
        errs++;
      end
      if (frame_done === 1'b1) fd++;
      @(negedge clk);
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL single_stream: %0d bad words want 0", errs); end
    n_checks++; if (fd !== 0) begin n_fail++; $display("FAIL single_early_done: %0d pulses want 0", fd); end
    n_checks++; if (frame_done !== 1'b1 || fc_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_end: frame_done=%b valid=%b want 1/0", frame_done, fc_valid);
    end
    @(negedge clk);
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", frame_done); end
    in_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    int fd = 0;
    int fd_k = -1;
    logic [31:0] exp_d;
    do_reset();
    fill_frame(0, 1);
    commit_frame();
    wait_valid();
    n_checks++; if (fc_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_start: valid got %b want 1", fc_valid); end
    fill_frame(2048, 1);
    n_checks++; if (fc_in_idx !== 10'd0 || fc_input !== 32'h0) begin
      n_fail++; $display("FAIL b2b_hold: idx=%0d data=%h want 0/00000000", fc_in_idx, fc_input);
    end
    commit_frame();
    n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_both_full: wr_rdy got %b want 0", wr_rdy); end
    in_rdy = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      exp_d = (k < 1024) ? word_of(k) : word_of(k - 1024 + 2048);
      if (fc_valid !== 1'b1 || fc_in_idx !== 10'(k % 1024) || fc_input !== exp_d) begin
        if (errs == 0) $display("note b2b first bad k=%0d idx=%0d data=%h", k, fc_in_idx, fc_input);
        errs++;
      end
      if (frame_done === 1'b1) begin fd++; fd_k = k; end
      if (k == 1023) begin
        n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_before: got %b want 0", wr_rdy); end
      end
      if (k == 1025) begin
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_after: got %b want 1", wr_rdy); end
      end
      @(negedge clk);
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_stream: %0d bad words want 0", errs); end
    n_checks++; if (fd !== 1 || fd_k !== 1024) begin n_fail++; $display("FAIL b2b_done: count=%0d at k=%0d want 1 at 1024", fd, fd_k); end
    n_checks++; if (frame_done !== 1'b1 || fc_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: frame_done=%b valid=%b want 1/0", frame_done, fc_valid);
    end
    in_rdy = 1'b0;
  endtask

  task automatic test_in_rdy_pattern();
    int errs = 0;
    int exp_i = 0;
    logic [3:0] pat;
    pat = 4'b1001;
    do_reset();
    fill_frame(4096, 1);
    commit_frame();
    wait_valid();
    for (int c = 0; c < 40; c++) begin
      if (fc_valid !== 1'b1 || fc_in_idx !== 10'(exp_i) || fc_input !== word_of(4096 + exp_i)) begin
        if (errs == 0) $display("note pattern first bad c=%0d idx=%0d data=%h", c, fc_in_idx, fc_input);
        errs++;
      end
      in_rdy = pat[c % 4];
      @(negedge clk);
      if (in_rdy) exp_i++;
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL pattern_stream: %0d bad cycles want 0", errs); end
    n_checks++; if (fc_in_idx !== 10'd20) begin n_fail++; $display("FAIL pattern_final_idx: got %0d want 20", fc_in_idx); end
    in_rdy = 1'b0;
  endtask

  task automatic test_loop();
    int errs = 0;
    int fd = 0;
    do_reset();
    fill_frame(1, 0);
    loop_en = 1'b1;
    commit_frame();
    wait_valid();
    in_rdy = 1'b1;
    for (int k = 0; k < 3072; k++) begin
      if (fc_valid !== 1'b1 || fc_in_idx !== 10'(k % 1024) || fc_input !== 32'h0001_0000 || wr_rdy !== 1'b1) begin
        if (errs == 0) $display("note loop first bad k=%0d idx=%0d data=%h rdy=%b", k, fc_in_idx, fc_input, wr_rdy);
        errs++;
      end
      if (frame_done === 1'b1) fd++;
      @(negedge clk);
    end
    if (frame_done === 1'b1) fd++;
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL loop_stream: %0d bad cycles want 0", errs); end
    n_checks++; if (fd !== 3) begin n_fail++; $display("FAIL loop_done_count: got %0d want 3", fd); end
    n_checks++; if (fc_valid !== 1'b1 || fc_in_idx !== 10'd0) begin
      n_fail++; $display("FAIL loop_wrap: valid=%b idx=%0d want 1/0", fc_valid, fc_in_idx);
    end
    in_rdy = 1'b0;
  endtask

  task automatic test_drop_writes();
    int errs = 0;
    int hits = 0;
    logic [31:0] exp_d;
    fill_frame(2, 0);
    commit_frame();
    n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL drop_full: wr_rdy got %b want 0", wr_rdy); end
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    wr_en = 1'b0;
    loop_en = 1'b0;
    in_rdy = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      exp_d = (k < 1024) ? 32'h0001_0000 : 32'h0002_0000;
      if (fc_valid !== 1'b1 || fc_in_idx !== 10'(k % 1024) || fc_input !== exp_d) begin
        if (errs == 0) $display("note drop first bad k=%0d idx=%0d data=%h", k, fc_in_idx, fc_input);
        errs++;
      end
      if (fc_in_idx === 10'd5 && fc_input === 32'hDEAD_BEEF) hits++;
      @(negedge clk);
    end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL drop_stream: %0d bad words want 0", errs); end
    n_checks++; if (hits !== 0) begin n_fail++; $display("FAIL drop_leak: DEADBEEF seen %0d times want 0", hits); end
    n_checks++; if (fc_valid !== 1'b0) begin n_fail++; $display("FAIL drop_end: valid got %b want 0", fc_valid); end
    in_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_frame(0, 1);
    commit_frame();
    wait_valid();
    in_rdy = 1'b1;
    for (int c = 0; c < 600 && fc_in_idx !== 10'd500; c++) @(negedge clk);
    n_checks++; if (fc_in_idx !== 10'd500) begin n_fail++; $display("FAIL mid_reach: idx got %0d want 500", fc_in_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (fc_valid !== 1'b0 || fc_in_idx !== 10'd0 || wr_rdy !== 1'b1 || fc_input !== 32'h0) begin
      n_fail++; $display("FAIL mid_async: valid=%b idx=%0d rdy=%b data=%h want 0/0/1/00000000", fc_valid, fc_in_idx, wr_rdy, fc_input);
    end
    in_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (fc_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: valid got %b want 0", fc_valid); end
    fill_frame(8192, 1);
    commit_frame();
    @(negedge clk);
    n_checks++; if (fc_valid !== 1'b1 || fc_in_idx !== 10'd0 || fc_input !== word_of(8192)) begin
      n_fail++; $display("FAIL mid_restart: valid=%b idx=%0d data=%h want 1/0/%h", fc_valid, fc_in_idx, fc_input, word_of(8192));
    end
    in_rdy = 1'b1;
    @(negedge clk);
    n_checks++; if (fc_in_idx !== 10'd1 || fc_input !== word_of(8193)) begin
      n_fail++; $display("FAIL mid_next: idx=%0d data=%h want 1/%h", fc_in_idx, fc_input, word_of(8193));
    end
    in_rdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_in_rdy_pattern();
    test_loop();
    test_drop_writes();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_feeder.md
Name: fc_feeder

Overview:
- Ping-pong input buffer and stream transmitter that feeds the fc layer's indexed input port (fc_input / fc_in_idx / in_rdy).
- An upstream producer (conv/pool stage) writes one frame of DEPTH Q16.16 words into a free bank, then commits it.
- The feeder streams committed frames to the fc layer in index order 0..DEPTH-1, advancing on each in_rdy.
- While one bank streams, the other bank fills, so the fc layer runs back-to-back frames.

Parameters:
- DEPTH, 1024, words per frame (fc input vector length).
- IDX_W, 10, index width; DEPTH <= 2**IDX_W.
- DATA_W, 32, word width (Q16.16 fixed point).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  upstream write strobe; honoured only when wr_rdy=1.
- wr_addr  in  IDX_W  word index within the write bank.
- wr_data  in  DATA_W  word to store.
- wr_commit  in  1  marks the write bank full; honoured only when wr_rdy=1.
- wr_rdy  out  1  a write bank is free and may be written.
- loop_en  in  1  replay the current frame when no other frame is committed.
- in_rdy  in  1  from fc layer: current word accepted at this edge.
- fc_valid  out  1  fc_input / fc_in_idx hold a valid word.
- fc_input  out  DATA_W  word at fc_in_idx of the streaming bank.
- fc_in_idx  out  IDX_W  index of the presented word.
- frame_done  out  1  one-cycle pulse when index DEPTH-1 is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - Both banks FREE; write bank = 0, read bank = 0.
  - Read FSM in IDLE.
  - Outputs: wr_rdy=1, fc_valid=0, fc_input=0, fc_in_idx=0, frame_done=0.
  - Buffer contents are don't-care.
  - Reset mid-stream or mid-fill discards all frames. The first post-reset frame is the first one committed after rst_n rises.
- Bank state: each bank is FREE or FULL. wr_rdy = (bank[wb]==FREE), registered.
- Write side:
  - When wr_en & wr_rdy: mem[wb][wr_addr] <= wr_data. Writes while wr_rdy=0 are dropped.
  - When wr_commit & wr_rdy: bank[wb] <= FULL and wb toggles.
  - wr_en and wr_commit in the same cycle store the word, then commit; the word is part of the frame.
  - Unwritten words within a committed frame stream stale data. No check is made.
- Read FSM states:
  - IDLE: fc_valid=0.
    - If bank[rb]==FULL: go to STREAM next cycle, fc_in_idx=0, fc_input=mem[rb][0].
    - Latency from wr_commit edge to fc_valid=1 is 2 cycles.
  - STREAM: fc_valid=1. On a clock edge with in_rdy=1:
    - If idx<DEPTH-1: idx <= idx+1 and fc_input <= mem[rb][idx+1]. fc_input always equals mem[rb][fc_in_idx] while fc_valid=1 (registered look-ahead read).
    - If idx==DEPTH-1: pulse frame_done.
      - Other bank FULL: bank[rb] <= FREE, rb toggles, stay in STREAM at idx 0 of the new bank. No bubble.
      - Else if loop_en=1: keep bank FULL, wrap idx to 0, replay.
      - Else: bank[rb] <= FREE, rb toggles, go to IDLE.
  - in_rdy=0 holds fc_in_idx / fc_input stable indefinitely.
  - in_rdy is ignored when fc_valid=0.
- Simultaneous events:
  - A commit of wb and a release of rb in the same cycle are both applied.
  - Both banks FULL gives wr_rdy=0.
  - A release makes wr_rdy=1 on the following cycle.
- Index arithmetic: unsigned IDX_W bits. The wrap compare uses DEPTH-1, not 2**IDX_W-1, so non-power-of-two DEPTH is supported.

Decomposition:
- Shared package fc_pkg:
  - Q16.16 width constant DATA_W = 32.
  - Default DEPTH / IDX_W for the fc layer.
  - Bank-state and read-FSM enums (BANK_FREE/BANK_FULL, RD_IDLE/RD_STREAM).
- One natural sub-module, fc_feeder_bank: single-bank DEPTH x DATA_W RAM with one synchronous write port and one asynchronous read port. It is instantiated twice; the top holds the FSMs and output registers.

Test Plan:
- Reset, fill bank 0 with word[i]={i,16'h0}, commit; in_rdy=1 -> fc_valid=1 two cycles after commit, fc_in_idx 0..1023 one per cycle, fc_input[31:16]=fc_in_idx, frame_done pulses once at idx 1023, then fc_valid=0.
- Fill bank 0, commit, fill bank 1 with {i+2048,16'h0}, commit during streaming -> idx 1023 of frame 0 is immediately followed by idx 0 with value 2048 (no gap). wr_rdy=0 while both are full and returns to 1 the cycle after the first frame_done.
- in_rdy toggles 1,0,0,1 pattern -> index advances only on in_rdy=1 edges; fc_input stays equal to the bank word at fc_in_idx throughout.
- loop_en=1 with a single frame {16'h1,16'h0} everywhere (fc_input=32'h00010000) -> stream wraps 1023->0 continuously with frame_done every 1024 accepts and wr_rdy=1 for bank 1 only.
- Writes with wr_rdy=0 (both banks full) to addr 5 with 32'hDEADBEEF -> the value never appears at fc_in_idx=5.
- Assert rst_n=0 at idx 500 of frame 0 -> fc_valid=0, fc_in_idx=0, wr_rdy=1 asynchronously; after release, the next committed frame streams from idx 0.
